// File: rtl/fir_coeff_pkg.sv
// rtl/fir_coeff_pkg.sv - shared defaults and scheduler state encoding for fir_coeff_sched
package fir_coeff_pkg;

  localparam int NREG_DEF = 6;
  localparam int CW_DEF   = 16;
  localparam int AW_DEF   = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_HI,
    ST_WR_LO,
    ST_COMMIT
  } sched_state_e;

  // Index width that stays legal for a single-entry request vector.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick: first request after the last granted index, cyclic
module rr_arbiter #(
  parameter int N  = 6,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  int j;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(last_i) + k) % N;
      if (!valid_o && req_i[IW'(j)]) begin
        valid_o          = 1'b1;
        idx_o            = IW'(j);
        grant_o[IW'(j)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fir_coeff_sched.sv
// rtl/fir_coeff_sched.sv - streams changed coefficient pairs into the FIR bank and commits batches
module fir_coeff_sched
  import fir_coeff_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int CW   = CW_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic                 user_clk,
  input  logic                 user_rst_n,
  input  logic [32*NREG-1:0]   reg_data,
  input  logic                 reload,
  output logic [AW-1:0]        coef_addr,
  output logic [CW-1:0]        coef_data,
  output logic                 coef_valid,
  input  logic                 coef_ready,
  output logic                 coef_commit,
  output logic                 busy,
  output logic [15:0]          upd_count
);

  localparam int IW = idx_w(NREG);

  sched_state_e               state_q, state_d;
  logic [NREG-1:0][31:0]      shadow_q, shadow_d;
  logic [NREG-1:0]            reload_q, reload_d;
  logic [IW-1:0]              last_q, last_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [31:0]                word_q, word_d;
  logic [15:0]                cnt_q, cnt_d;

  logic [NREG-1:0]            pending;
  logic [NREG-1:0]            grant;
  logic [IW-1:0]              grant_idx;
  logic                       any_pend;
  logic [31:0]                sel_word;

  always_comb begin
    pending = '0;
    for (int i = 0; i < NREG; i++) begin
      pending[i] = (reg_data[32*i +: 32] != shadow_q[i]) | reload_q[i];
    end
  end

  rr_arbiter #(
    .N  (NREG),
    .IW (IW)
  ) u_arb (
    .req_i   (pending),
    .last_i  (last_q),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .valid_o (any_pend)
  );

  assign sel_word = reg_data[32*int'(grant_idx) +: 32];

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    reload_d = reload_q;
    last_d   = last_q;
    idx_d    = idx_q;
    word_d   = word_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (any_pend) begin
          for (int i = 0; i < NREG; i++) begin
            if (grant[i]) shadow_d[i] = reg_data[32*i +: 32];
          end
          reload_d = reload_q & ~grant;
          word_d   = sel_word;
          idx_d    = grant_idx;
          last_d   = grant_idx;
          state_d  = ST_WR_HI;
        end
      end
      ST_WR_HI: begin
        if (coef_ready) state_d = ST_WR_LO;
      end
      ST_WR_LO: begin
        if (coef_ready) begin
          cnt_d   = cnt_q + 16'd1;
          // More work queued: keep batching and defer the commit.
          state_d = any_pend ? ST_IDLE : ST_COMMIT;
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (reload) reload_d = '1;
  end

  always_comb begin
    coef_valid  = 1'b0;
    coef_commit = 1'b0;
    coef_addr   = '0;
    coef_data   = '0;
    busy        = (state_q != ST_IDLE);
    upd_count   = cnt_q;
    case (state_q)
      ST_WR_HI: begin
        coef_valid = 1'b1;
        coef_addr  = AW'(2 * int'(idx_q));
        coef_data  = CW'(word_q[31:16]);
      end
      ST_WR_LO: begin
        coef_valid = 1'b1;
        coef_addr  = AW'(2 * int'(idx_q) + 1);
        coef_data  = CW'(word_q[15:0]);
      end
      ST_COMMIT: coef_commit = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q  <= ST_IDLE;
      shadow_q <= '0;
      reload_q <= '0;
      last_q   <= IW'(NREG - 1);
      idx_q    <= '0;
      word_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      reload_q <= reload_d;
      last_q   <= last_d;
      idx_q    <= idx_d;
      word_q   <= word_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fir_coeff_sched.sv
// tb/tb_fir_coeff_sched.sv - self-checking bench for fir_coeff_sched with a transaction-queue model
module tb_fir_coeff_sched;

  localparam int NREG = 6;
  localparam int CW   = 16;
  localparam int AW   = 4;

  logic                 user_clk;
  logic                 user_rst_n;
  logic [32*NREG-1:0]   reg_data;
  logic                 reload;
  logic [AW-1:0]        coef_addr;
  logic [CW-1:0]        coef_data;
  logic                 coef_valid;
  logic                 coef_ready;
  logic                 coef_commit;
  logic                 busy;
  logic [15:0]          upd_count;

  fir_coeff_sched dut (
    .user_clk    (user_clk),
    .user_rst_n  (user_rst_n),
    .reg_data    (reg_data),
    .reload      (reload),
    .coef_addr   (coef_addr),
    .coef_data   (coef_data),
    .coef_valid  (coef_valid),
    .coef_ready  (coef_ready),
    .coef_commit (coef_commit),
    .busy        (busy),
    .upd_count   (upd_count)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each grant queues its two writes; a drained queue with nothing pending commits.
  logic [31:0] m_shadow [NREG];
  bit          m_flag   [NREG];
  int          m_last;
  int          q_addr [$];
  int          q_data [$];
  bit          m_commit;
  logic [15:0] m_cnt;
  bit          m_anyp;
  int          m_g;
  logic [31:0] m_w;

  function automatic bit m_pend(input int i);
    return (reg_data[32*i +: 32] !== m_shadow[i]) || m_flag[i];
  endfunction

  always @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        m_shadow[i] = 32'h0;
        m_flag[i]   = 1'b0;
      end
      m_last   = NREG - 1;
      q_addr.delete();
      q_data.delete();
      m_commit = 1'b0;
      m_cnt    = 16'h0;
    end else begin
      m_anyp = 1'b0;
      for (int i = 0; i < NREG; i++) m_anyp = m_anyp | m_pend(i);
      if (m_commit) begin
        m_commit = 1'b0;
      end else if (q_addr.size() != 0) begin
        if (coef_ready) begin
          void'(q_addr.pop_front());
          void'(q_data.pop_front());
          if (q_addr.size() == 0) begin
            m_cnt    = m_cnt + 16'd1;
            m_commit = !m_anyp;
          end
        end
      end else if (m_anyp) begin
        m_g = -1;
        for (int k = 1; k <= NREG; k++) begin
          if (m_g < 0 && m_pend((m_last + k) % NREG)) m_g = (m_last + k) % NREG;
        end
        m_w = reg_data[32*m_g +: 32];
        m_shadow[m_g] = m_w;
        m_flag[m_g]   = 1'b0;
        m_last        = m_g;
        q_addr.push_back(2*m_g);
        q_data.push_back(int'(m_w[31:16]));
        q_addr.push_back(2*m_g + 1);
        q_data.push_back(int'(m_w[15:0]));
      end
      if (reload) for (int i = 0; i < NREG; i++) m_flag[i] = 1'b1;
    end
  end

  int log_addr [$];
  int log_data [$];
  int n_commit = 0;

  always @(negedge user_clk) begin
    check("valid", coef_valid, q_addr.size() != 0);
    check("commit", coef_commit, m_commit);
    check("busy", busy, (q_addr.size() != 0) || m_commit);
    check("upd_count", upd_count, m_cnt);
    check("valid_commit_excl", coef_valid & coef_commit, 0);
    if (coef_valid && q_addr.size() != 0) begin
      check("addr", coef_addr, q_addr[0]);
      check("data", coef_data, q_data[0]);
    end
    if (user_rst_n && coef_valid && coef_ready) begin
      log_addr.push_back(int'(coef_addr));
      log_data.push_back(int'(coef_data));
    end
    if (user_rst_n && coef_commit) n_commit++;
  end

  int exp_a [$];
  int exp_d [$];

  task automatic exp_push(input int a, input int d);
    exp_a.push_back(a);
    exp_d.push_back(d);
  endtask

  task automatic compare_log(input string name);
    check({name, "_len"}, log_addr.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < log_addr.size(); i++) begin
      check({name, "_addr"}, log_addr[i], exp_a[i]);
      check({name, "_data"}, log_data[i], exp_d[i]);
    end
    exp_a.delete();
    exp_d.delete();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic wait_commit(input string name, input int budget);
    int c0;
    int t;
    c0 = n_commit;
    t  = 0;
    while (n_commit == c0 && t < budget) begin
      tick();
      t++;
    end
    check({name, "_commit_seen"}, n_commit != c0, 1);
    repeat (8) tick();
  endtask

  task automatic set_reg(input int i, input logic [31:0] v);
    reg_data[32*i +: 32] = v;
  endtask

  int idle_bad;
  int t;

  initial begin
    user_rst_n = 1'b0;
    reg_data   = '0;
    reload     = 1'b0;
    coef_ready = 1'b1;
    repeat (3) tick();
    check("rst_valid", coef_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_commit", coef_commit, 0);
    check("rst_addr", coef_addr, 0);
    check("rst_data", coef_data, 0);
    check("rst_upd", upd_count, 0);
    user_rst_n = 1'b1;

    idle_bad = 0;
    repeat (100) begin
      tick();
      if (coef_valid || busy) idle_bad++;
    end
    check("idle_100", idle_bad, 0);
    check("idle_log", log_addr.size(), 0);

    n_commit = 0;
    set_reg(5, 32'h1234ABCD);
    tick();
    check("latency_valid", coef_valid, 1);
    check("latency_addr", coef_addr, 10);
    wait_commit("single", 50);
    exp_push(10, 16'h1234);
    exp_push(11, 16'hABCD);
    compare_log("single");
    check("single_commits", n_commit, 1);
    check("single_upd", upd_count, 1);

    n_commit = 0;
    set_reg(1, 32'h11112222);
    set_reg(3, 32'h33334444);
    wait_commit("pair13", 60);
    exp_push(2, 16'h1111);
    exp_push(3, 16'h2222);
    exp_push(6, 16'h3333);
    exp_push(7, 16'h4444);
    compare_log("pair13");
    check("pair13_commits", n_commit, 1);
    check("pair13_upd", upd_count, 3);

    n_commit = 0;
    coef_ready = 1'b0;
    set_reg(5, 32'h55556666);
    tick();
    check("stall_valid0", coef_valid, 1);
    check("stall_addr0", coef_addr, 10);
    check("stall_data0", coef_data, 16'h5555);
    set_reg(5, 32'h0);
    repeat (5) begin
      tick();
      check("stall_valid", coef_valid, 1);
      check("stall_addr", coef_addr, 10);
      check("stall_data", coef_data, 16'h5555);
    end
    coef_ready = 1'b1;
    wait_commit("stall", 60);
    exp_push(10, 16'h5555);
    exp_push(11, 16'h6666);
    exp_push(10, 16'h0000);
    exp_push(11, 16'h0000);
    compare_log("stall");
    check("stall_commits", n_commit, 1);
    check("stall_upd", upd_count, 5);

    n_commit = 0;
    reload = 1'b1;
    tick();
    reload = 1'b0;
    wait_commit("reload", 100);
    exp_push(0, 16'h0000);  exp_push(1, 16'h0000);
    exp_push(2, 16'h1111);  exp_push(3, 16'h2222);
    exp_push(4, 16'h0000);  exp_push(5, 16'h0000);
    exp_push(6, 16'h3333);  exp_push(7, 16'h4444);
    exp_push(8, 16'h0000);  exp_push(9, 16'h0000);
    exp_push(10, 16'h0000); exp_push(11, 16'h0000);
    compare_log("reload");
    check("reload_commits", n_commit, 1);
    check("reload_upd", upd_count, 11);

    set_reg(2, 32'h00010002);
    t = 0;
    while (!(coef_valid && coef_addr == 4'd5) && t < 20) begin
      tick();
      t++;
    end
    check("reach_wr_lo", coef_valid && coef_addr == 4'd5, 1);
    user_rst_n = 1'b0;
    #1;
    check("mid_rst_valid", coef_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_commit", coef_commit, 0);
    check("mid_rst_addr", coef_addr, 0);
    check("mid_rst_data", coef_data, 0);
    check("mid_rst_upd", upd_count, 0);
    repeat (2) tick();
    log_addr.delete();
    log_data.delete();
    n_commit = 0;
    user_rst_n = 1'b1;
    wait_commit("post_rst", 100);
    exp_push(2, 16'h1111);
    exp_push(3, 16'h2222);
    exp_push(4, 16'h0001);
    exp_push(5, 16'h0002);
    exp_push(6, 16'h3333);
    exp_push(7, 16'h4444);
    compare_log("post_rst");
    check("post_rst_commits", n_commit, 1);
    check("post_rst_upd", upd_count, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

endmodule
